// File: rtl/vibrato_param_out.sv
// Vibrato parameter output port: an Avalon-MM slave holding a CPU-written target
// and an active value driven onto out_port. The active value only moves on
// sample_tick (jump or one-LSB ramp) or on an explicit force-commit.
module vibrato_param_out #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic             sample_tick,
  output logic [WIDTH-1:0] out_port,
  output logic             update_pending
);

  localparam int unsigned PadW = 32 - WIDTH;

  localparam logic [1:0] AddrTarget = 2'd0;
  localparam logic [1:0] AddrActive = 2'd1;
  localparam logic [1:0] AddrCtrl   = 2'd2;
  localparam logic [1:0] AddrStatus = 2'd3;

  logic [WIDTH-1:0] r_target;
  logic [WIDTH-1:0] r_active;
  logic             r_ramp_en;
  logic             r_hold;
  logic [31:0]      r_readdata;

  logic             w_wr;
  logic             w_force;
  logic [WIDTH-1:0] w_active_d;
  logic [31:0]      w_rdata;
  logic             w_unused_wdata;

  assign w_wr    = chipselect & ~write_n;
  assign w_force = w_wr & (address == AddrStatus);

  // Upper write-data bits beyond the register widths carry no meaning.
  assign w_unused_wdata = ^writedata[31:WIDTH];

  // Next active value: force-commit overrides any tick; hold freezes ticks.
  always_comb begin
    w_active_d = r_active;
    if (w_force) begin
      w_active_d = r_target;
    end else if (sample_tick && !r_hold) begin
      if (!r_ramp_en) begin
        w_active_d = r_target;
      end else if (r_active < r_target) begin
        w_active_d = r_active + 1'b1;
      end else if (r_active > r_target) begin
        w_active_d = r_active - 1'b1;
      end
    end
  end

  // Read mux sees pre-edge register values, giving one clock of read latency.
  always_comb begin
    w_rdata = 32'd0;
    unique case (address)
      AddrTarget: w_rdata = {{PadW{1'b0}}, r_target};
      AddrActive: w_rdata = {{PadW{1'b0}}, r_active};
      AddrCtrl:   w_rdata = {30'd0, r_hold, r_ramp_en};
      AddrStatus: w_rdata = {31'd0, update_pending};
      default:    w_rdata = 32'd0;
    endcase
  end

  // CPU-writable registers: target and ctrl.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_target  <= '0;
      r_ramp_en <= 1'b0;
      r_hold    <= 1'b0;
    end else if (w_wr) begin
      if (address == AddrTarget) begin
        r_target <= writedata[WIDTH-1:0];
      end
      if (address == AddrCtrl) begin
        r_ramp_en <= writedata[0];
        r_hold    <= writedata[1];
      end
    end
  end

  // Active value register, which is out_port itself.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_active <= '0;
    end else begin
      r_active <= w_active_d;
    end
  end

  // Registered read data, updated every edge regardless of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= 32'd0;
    end else begin
      r_readdata <= w_rdata;
    end
  end

  assign out_port       = r_active;
  assign update_pending = (r_active != r_target);
  assign readdata       = r_readdata;

endmodule

// File: tb/tb_vibrato_param_out.sv
// Self-checking bench for vibrato_param_out: a directed vector table, a few
// hand-written corner sequences, and randomized traffic against a register-level
// model kept as plain integers.
module tb_vibrato_param_out;

  localparam int unsigned W    = 8;
  localparam int unsigned MASK = (1 << W) - 1;

  logic          clk;
  logic          reset_n;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic          sample_tick;
  logic [W-1:0]  out_port;
  logic          update_pending;

  int checks;
  int errors;

  // Reference model state
  int unsigned m_target;
  int unsigned m_active;
  int unsigned m_ramp;
  int unsigned m_hold;
  int unsigned m_rd;

  typedef struct {
    logic [1:0]  addr;
    logic        wr;
    logic [31:0] wd;
    logic        tick;
    int unsigned exp_out;
    logic        exp_pend;
    int unsigned exp_rd;
  } vec_t;

  vibrato_param_out #(.WIDTH(W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .address        (address),
    .chipselect     (chipselect),
    .write_n        (write_n),
    .writedata      (writedata),
    .readdata       (readdata),
    .sample_tick    (sample_tick),
    .out_port       (out_port),
    .update_pending (update_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_target = 0;
    m_active = 0;
    m_ramp   = 0;
    m_hold   = 0;
    m_rd     = 0;
  endtask

  // One clock of register-level behaviour, evaluated on the pre-edge state.
  task automatic model_step(input logic [1:0] a, input logic wr, input logic [31:0] wd,
                            input logic tick);
    int unsigned nt, na;
    nt = m_target;
    na = m_active;
    case (a)
      2'd0: m_rd = m_target;
      2'd1: m_rd = m_active;
      2'd2: m_rd = m_hold * 2 + m_ramp;
      default: m_rd = (m_active != m_target) ? 1 : 0;
    endcase
    if (wr && a == 2'd3) begin
      na = m_target;
    end else if (tick && m_hold == 0) begin
      if (m_ramp == 0) na = m_target;
      else if (m_active < m_target) na = m_active + 1;
      else if (m_active > m_target) na = m_active - 1;
    end
    if (wr && a == 2'd0) nt = wd & MASK;
    if (wr && a == 2'd2) begin
      m_ramp = wd & 1;
      m_hold = (wd >> 1) & 1;
    end
    m_target = nt;
    m_active = na;
  endtask

  // Drive one cycle (inputs set away from the edge), advance model, sample at edge+1.
  task automatic do_cycle(input logic [1:0] a, input logic wr, input logic [31:0] wd,
                          input logic tick);
    address     = a;
    chipselect  = wr ? 1'b1 : logic'($urandom_range(0, 1));
    write_n     = ~wr;
    writedata   = wd;
    sample_tick = tick;
    model_step(a, wr, wd, tick);
    @(posedge clk);
    #1;
    chipselect  = 1'b0;
    write_n     = 1'b1;
    sample_tick = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".out_port"}, out_port, m_active);
    check({tag, ".pending"}, update_pending, (m_active != m_target) ? 1 : 0);
    check({tag, ".readdata"}, readdata, m_rd);
  endtask

  vec_t vecs[$];

  task automatic add(input logic [1:0] a, input logic wr, input logic [31:0] wd,
                     input logic tick, input int unsigned eo, input logic ep,
                     input int unsigned er);
    vec_t v;
    v.addr = a; v.wr = wr; v.wd = wd; v.tick = tick;
    v.exp_out = eo; v.exp_pend = ep; v.exp_rd = er;
    vecs.push_back(v);
  endtask

  initial begin
    int budget;
    checks      = 0;
    errors      = 0;
    address     = 2'd0;
    chipselect  = 1'b0;
    write_n     = 1'b1;
    writedata   = 32'd0;
    sample_tick = 1'b0;
    reset_n     = 1'b0;
    model_reset();

    // Reset state before any clock edge
    #1;
    check("reset.out_port", out_port, 0);
    check("reset.pending", update_pending, 0);
    check("reset.readdata", readdata, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    for (int a = 0; a < 4; a++) begin
      do_cycle(a[1:0], 1'b0, 32'd0, 1'b0);
      check($sformatf("post_reset_rd%0d", a), readdata, 0);
    end

    // addr, wr, wdata, tick, exp out_port, exp pending, exp readdata
    add(2'd0, 1, 32'hA5,  0, 8'h00, 1, 0);     // target write, no commit yet
    add(2'd0, 0, 0,       1, 8'hA5, 0, 8'hA5); // direct commit on tick
    add(2'd0, 1, 32'h1A5, 0, 8'hA5, 0, 8'hA5); // upper bits dropped
    add(2'd0, 0, 0,       0, 8'hA5, 0, 8'hA5);
    add(2'd0, 1, 0,       1, 8'hA5, 1, 8'hA5); // tick uses old target
    add(2'd1, 0, 0,       1, 8'h00, 0, 8'hA5);
    add(2'd2, 1, 1,       0, 8'h00, 0, 0);     // ramp_en=1
    add(2'd0, 1, 3,       0, 8'h00, 1, 0);
    add(2'd1, 0, 0,       1, 1,     1, 0);
    add(2'd1, 0, 0,       1, 2,     1, 1);
    add(2'd1, 0, 0,       1, 3,     0, 2);
    add(2'd1, 0, 0,       1, 3,     0, 3);     // no overshoot
    add(2'd0, 1, 1,       0, 3,     1, 3);
    add(2'd1, 0, 0,       1, 2,     1, 3);
    add(2'd1, 0, 0,       1, 1,     0, 2);
    add(2'd2, 0, 0,       0, 1,     0, 1);
    add(2'd3, 0, 0,       0, 1,     0, 0);
    add(2'd2, 1, 3,       0, 1,     0, 1);     // hold + ramp
    add(2'd0, 1, 32'h40,  0, 1,     1, 1);
    for (int i = 0; i < 5; i++) add(2'd3, 0, 0, 1, 1, 1, 1); // ticks ignored
    add(2'd3, 1, 0,       0, 8'h40, 0, 1);     // force-commit under hold
    add(2'd2, 0, 0,       0, 8'h40, 0, 3);
    add(2'd2, 1, 0,       0, 8'h40, 0, 3);     // direct mode
    add(2'd0, 1, 0,       0, 8'h40, 1, 8'h40);
    add(2'd0, 0, 0,       1, 0,     0, 0);
    add(2'd0, 1, 32'h10,  1, 0,     1, 0);     // write coincident with tick
    add(2'd1, 0, 0,       1, 8'h10, 0, 0);
    add(2'd2, 1, 1,       0, 8'h10, 0, 0);     // ramp mode
    add(2'd0, 1, 32'h20,  0, 8'h10, 1, 8'h10);
    add(2'd3, 1, 0,       1, 8'h20, 0, 1);     // force beats tick, no extra step
    add(2'd1, 0, 0,       1, 8'h20, 0, 8'h20);
    add(2'd2, 1, 3,       0, 8'h20, 0, 1);
    add(2'd2, 0, 0,       0, 8'h20, 0, 3);     // ctrl readback one clock later
    add(2'd2, 1, 0,       0, 8'h20, 0, 3);

    foreach (vecs[i]) begin
      do_cycle(vecs[i].addr, vecs[i].wr, vecs[i].wd, vecs[i].tick);
      check($sformatf("vec%0d.out_port", i), out_port, vecs[i].exp_out);
      check($sformatf("vec%0d.pending", i), update_pending, vecs[i].exp_pend);
      check($sformatf("vec%0d.readdata", i), readdata, vecs[i].exp_rd);
    end

    // Full-scale ramp 0 -> 255: pending must clear after exactly 255 ticks
    do_cycle(2'd0, 1'b1, 32'd0, 1'b0);
    do_cycle(2'd0, 1'b0, 32'd0, 1'b1);
    do_cycle(2'd2, 1'b1, 32'd1, 1'b0);
    do_cycle(2'd0, 1'b1, 32'hFF, 1'b0);
    check_model("ramp_start");
    budget = 0;
    while (update_pending === 1'b1 && budget < 400) begin
      do_cycle(2'd1, 1'b0, 32'd0, 1'b1);
      budget++;
    end
    check("ramp255.ticks", budget, 255);
    check("ramp255.out_port", out_port, 255);
    check_model("ramp_end");

    // Asynchronous reset in the middle of a downward ramp
    do_cycle(2'd0, 1'b1, 32'd0, 1'b0);
    for (int i = 0; i < 7; i++) do_cycle(2'd1, 1'b0, 32'd0, 1'b1);
    check_model("pre_reset");
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset.out_port", out_port, 0);
    check("midreset.pending", update_pending, 0);
    check("midreset.readdata", readdata, 0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Randomized traffic; targets kept near active so ramps actually finish
    for (int n = 0; n < 3000; n++) begin
      logic [1:0]  a;
      logic        wr;
      logic [31:0] wd;
      logic        tk;
      a  = 2'($urandom_range(0, 3));
      wr = ($urandom_range(0, 99) < 25);
      wd = $urandom;
      if (a == 2'd0 && $urandom_range(0, 3) != 0)
        wd = (wd & 32'hFFFF_FF00) | ((m_active + $urandom_range(0, 12) - 6) & MASK);
      if (a == 2'd2 && $urandom_range(0, 3) != 0) wd = wd & 32'hFFFF_FFFD;
      tk = ($urandom_range(0, 99) < 40);
      do_cycle(a, wr, wd, tk);
      check_model($sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vibrato_param_out.md
# vibrato_param_out

Avalon-MM write-side parameter port for the vibrato effect: the CPU writes a target value, and the block drives it onto `out_port` toward the audio datapath. Updates are committed only on `sample_tick` strobes, either in one jump or ramped one LSB per tick, so the effect parameter never changes mid-sample and never steps audibly. It sits on the same Avalon bus as the input PIOs and is the output-direction counterpart of the vibrato enable input.

## Interface
Parameters:
- WIDTH, 8, width of the target, active value and out_port (1..31)

Ports:
- Clock and reset: `clk` and `reset_n`, asynchronous, active-low.
- clk  in  1  system clock; all logic on its rising edge
- reset_n  in  1  asynchronous active-low reset
- address  in  2  Avalon register select
- chipselect  in  1  Avalon slave select
- write_n  in  1  active-low write strobe; write occurs when chipselect=1 and write_n=0
- writedata  in  32  write data; bits above WIDTH-1 ignored for addr 0
- readdata  out  32  registered read data, zero-extended
- sample_tick  in  1  one-clk strobe per audio sample, synchronous to clk
- out_port  out  WIDTH  active parameter value (register output, no glitching)
- update_pending  out  1  1 while active != target

## Operation
- Registers:
  - target[WIDTH-1:0], at addr 0, R/W.
  - active[WIDTH-1:0], at addr 1, RO; writes are ignored.
  - ctrl, at addr 2, R/W: bit0 ramp_en, bit1 hold.
  - Addr 3: read returns {31'b0, update_pending}; a write of any value is a force-commit.
- Read path:
  - readdata <= mux(address) every clk edge, independent of chipselect.
  - Unused bits read 0.
- Commit on sample_tick when hold=0 and ramp_en=0: active <= target.
- Ramp on sample_tick when hold=0 and ramp_en=1:
  - active < target: active <= active+1.
  - active > target: active <= active-1.
  - Equal: no change.
  - Unsigned compare. active never overshoots and never wraps.
- hold=1: sample_tick is ignored and active is frozen. target may still be written.
- Force-commit (write to addr 3): active <= target at that edge, regardless of hold, ramp_en or sample_tick.
- out_port = active. update_pending = (active != target), combinational from the registers.

## Timing
- Reset: target=0, active=0, ctrl=0, readdata=0, out_port=0, update_pending=0.
- Write at cycle n: the register holds the new value after edge n. readdata reflects it when addressed at cycle n+1, visible after edge n+1.
- Read latency: 1 clk from address to readdata.
- Write to addr 0 in the same cycle as sample_tick:
  - The tick uses the old target.
  - The new target is applied at the next tick.
  - update_pending goes 1 after that edge.
- Write to addr 2 in the same cycle as sample_tick: the tick uses the old ctrl.
- Force-commit in the same cycle as sample_tick: force wins, and active = pre-write target.
- Force-commit in the same cycle as a target write is impossible, since there is one address per cycle.
- Ramp length: |target−active| ticks. Example: 0→255 with WIDTH=8 takes 255 ticks.
- Reset mid-ramp: all registers return to 0 asynchronously. out_port=0 immediately, with no clk needed.
- Back-to-back sample_tick on consecutive cycles is legal; each tick is processed.

## Test plan
- Reset values: assert reset_n=0 mid-activity → out_port=0, readdata=0 and update_pending=0 with no clk edge; after release, reading addrs 0-3 returns 0.
- Direct commit, WIDTH=8, ramp_en=0: write 0xA5 to addr 0 → update_pending=1 and out_port still 0; pulse sample_tick → out_port=0xA5 next edge and update_pending=0. Write 0x1A5 → target reads 0xA5.
- Ramp, ramp_en=1:
  - Target 3 from active 0: 3 ticks give out_port 1, 2, 3; the 4th tick leaves 3.
  - Then target 1: 2 ticks give 2, 1.
- Hold and force: set hold=1, write target 0x40, pulse 5 ticks → out_port unchanged and update_pending=1. Write addr 3 → out_port=0x40 next edge.
- Collision cases:
  - Write target 0x10 in the same cycle as a tick (active 0, old target 0) → out_port stays 0, update_pending=1; the next tick sets out_port=0x10.
  - Force-commit coincident with a tick → active = target, with no extra ramp step.
- Readback latency: write ctrl=0x3, then read addr 2 → readdata=0x00000003 exactly 1 clk after the address is presented; read addr 1 during a ramp → readdata tracks out_port with 1 clk delay.
